tc_uart_rx_port: RTL and testbench



---
 rtl/tc_io_pkg.sv | 18 +
 rtl/tc_sync_fifo.sv | 59 +++++
 rtl/tc_uart_rx_port.sv | 130 +++++++++++++
 tb/tb_tc_uart_rx_port.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/tc_io_pkg.sv
// Shared types and field positions for the tiny computer's serial input port.
package tc_io_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAITHI
  } rx_state_t;

  localparam int RX_DATA_BITS = 8;
  localparam int RX_ENTRY_W   = 9;
  localparam int IN_WORD_W    = 32;
  localparam int FERR_BIT     = 8;
  localparam int OVR_BIT      = 9;

endpackage

// File: rtl/tc_sync_fifo.sv
// Synchronous circular FIFO with a combinational head output (zero when empty).
module tc_sync_fifo #(
  parameter int WIDTH = 9,
  parameter int AW    = 3
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic [AW:0]      count_o
);

  localparam logic [AW:0] DEPTH = (AW + 1)'(2 ** AW);

  logic [WIDTH-1:0] mem_q [2 ** AW];
  logic [AW-1:0]    rd_ptr_q;
  logic [AW-1:0]    wr_ptr_q;
  logic [AW:0]      count_q;
  logic             empty;
  logic             do_pop;
  logic             do_push;

  assign empty   = (count_q == '0);
  assign full_o  = (count_q == DEPTH);
  assign count_o = count_q;

  // A pop on an empty FIFO is ignored; a push into a full FIFO is only
  // accepted when a pop frees the slot on the same edge.
  assign do_pop  = pop_i & ~empty;
  assign do_push = push_i & (~full_o | do_pop);

  // NOTE: storage has no reset; the count and pointers alone define which entries are valid.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign rdata_o = empty ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/tc_uart_rx_port.sv
// 8N1 serial receiver feeding a small FIFO, presented to the processor as InData/InRdy.
module tc_uart_rx_port
  import tc_io_pkg::*;
#(
  parameter int DIVISOR = 434,
  parameter int FIFO_AW = 3
) (
  input  logic                 Ph0,
  input  logic                 Reset,
  input  logic                 RxD,
  input  logic                 InStrobe,
  output logic [IN_WORD_W-1:0] InData,
  output logic                 InRdy,
  output logic                 RxBusy
);

  localparam logic [15:0] BIT_LAST  = 16'(DIVISOR - 1);
  localparam logic [15:0] HALF_LAST = 16'(DIVISOR / 2 - 1);
  localparam logic [2:0]  LAST_BIT  = 3'(RX_DATA_BITS - 1);

  logic                    rx_meta_q;
  logic                    rxs_q;
  rx_state_t               state_q;
  logic [15:0]             cnt_q;
  logic [2:0]              bit_idx_q;
  logic [RX_DATA_BITS-1:0] shreg_q;
  logic                    ovr_q;
  logic                    ovr_d;

  logic                    push;
  logic                    pop;
  logic                    fifo_full;
  logic [FIFO_AW:0]        fifo_count;
  logic [RX_ENTRY_W-1:0]   push_entry;
  logic [RX_ENTRY_W-1:0]   head;

  // Synchronizer idles high so reset never looks like a start bit.
  always_ff @(posedge Ph0) begin
    if (Reset) begin
      rx_meta_q <= 1'b1;
      rxs_q     <= 1'b1;
    end else begin
      rx_meta_q <= RxD;
      rxs_q     <= rx_meta_q;
    end
  end

  always_ff @(posedge Ph0) begin
    if (Reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shreg_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (!rxs_q) begin
            state_q <= START;
            cnt_q   <= '0;
          end
        end
        START: begin
          if (cnt_q == HALF_LAST) begin
            cnt_q     <= '0;
            bit_idx_q <= '0;
            state_q   <= rxs_q ? IDLE : DATA;
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        DATA: begin
          if (cnt_q == BIT_LAST) begin
            cnt_q     <= '0;
            shreg_q   <= {rxs_q, shreg_q[RX_DATA_BITS-1:1]};
            bit_idx_q <= bit_idx_q + 3'd1;
            if (bit_idx_q == LAST_BIT) state_q <= STOP;
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        STOP: begin
          if (cnt_q == BIT_LAST) begin
            cnt_q   <= '0;
            state_q <= rxs_q ? IDLE : WAITHI;
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        // A held-low line (break) must go high before another frame can start.
        WAITHI:  if (rxs_q) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign push       = (state_q == STOP) && (cnt_q == BIT_LAST);
  assign push_entry = {~rxs_q, shreg_q};
  assign pop        = InStrobe & InRdy;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    ovr_d = ovr_q;
    if (pop) ovr_d = 1'b0;
    if (push && fifo_full && !pop) ovr_d = 1'b1;
  end

  always_ff @(posedge Ph0) begin
    if (Reset) ovr_q <= 1'b0;
    else       ovr_q <= ovr_d;
  end

  tc_sync_fifo #(
    .WIDTH (RX_ENTRY_W),
    .AW    (FIFO_AW)
  ) u_fifo (
    .clk_i   (Ph0),
    .rst_i   (Reset),
    .push_i  (push),
    .pop_i   (InStrobe),
    .wdata_i (push_entry),
    .rdata_o (head),
    .full_o  (fifo_full),
    .count_o (fifo_count)
  );

  assign InRdy  = (fifo_count != '0);
  assign InData = InRdy ? {{(IN_WORD_W - OVR_BIT - 1){1'b0}}, ovr_q, head} : '0;
  assign RxBusy = (state_q != IDLE);

endmodule

// File: tb/tb_tc_uart_rx_port.sv
// Self-checking bench for tc_uart_rx_port: directed frames, FIFO corner cases, random traffic.
module tb_tc_uart_rx_port;

  localparam int DIV   = 8;
  localparam int AW    = 2;
  localparam int DEPTH = 4;

  logic        Ph0      = 1'b0;
  logic        Reset    = 1'b1;
  logic        RxD      = 1'b1;
  logic        InStrobe = 1'b0;
  logic [31:0] InData;
  logic        InRdy;
  logic        RxBusy;

  int total = 0;
  int bad   = 0;

  // Reference: queue of {ferr, data} entries plus a sticky overrun bit.
  logic [8:0] mq[$];
  bit         movr;

  typedef struct {
    logic [7:0]  data;
    bit          stop;
    logic [31:0] exp_word;
  } vec_t;

  vec_t vecs[5];

  tc_uart_rx_port #(
    .DIVISOR (DIV),
    .FIFO_AW (AW)
  ) dut (
    .Ph0      (Ph0),
    .Reset    (Reset),
    .RxD      (RxD),
    .InStrobe (InStrobe),
    .InData   (InData),
    .InRdy    (InRdy),
    .RxBusy   (RxBusy)
  );

  always #5 Ph0 = ~Ph0;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge Ph0);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic model_event(input bit push, input logic [8:0] e, input bit pop);
    if (pop && mq.size() > 0) begin
      mq.delete(0);
      movr = 1'b0;
    end
    if (push) begin
      if (mq.size() < DEPTH) mq.push_back(e);
      else                   movr = 1'b1;
    end
  endtask

  function automatic logic [31:0] model_word();
    if (mq.size() == 0) return 32'h0;
    return {22'b0, movr, mq[0]};
  endfunction

  task automatic model_clear();
    mq.delete();
    movr = 1'b0;
  endtask

  // Drives one 8N1 frame; optionally raises InStrobe for the clock before edge number strobe_at+1.
  task automatic send_frame(input logic [7:0] d, input bit stop, input int strobe_at,
                            output int rdy_tick, output logic [31:0] strobe_word);
    logic [9:0] fr;
    int         n;
    bit         strobe_hit;
    fr          = {stop, d, 1'b0};
    n           = 0;
    rdy_tick    = -1;
    strobe_word = 32'h0;
    strobe_hit  = 1'b0;
    for (int b = 0; b < 10; b++) begin
      RxD = fr[b];
      for (int k = 0; k < DIV; k++) begin
        InStrobe = (n == strobe_at);
        if (InStrobe) begin
          strobe_word = InData;
          strobe_hit  = InRdy;
        end
        tick();
        n++;
        if (InRdy && rdy_tick < 0) rdy_tick = n;
      end
    end
    InStrobe = 1'b0;
    model_event(1'b1, {~stop, d}, strobe_hit);
  endtask

  task automatic idle(input int n);
    RxD = 1'b1;
    repeat (n) tick();
  endtask

  task automatic pop_check(input string name, input logic [31:0] exp);
    check(name, InData, exp);
    InStrobe = 1'b1;
    tick();
    InStrobe = 1'b0;
    model_event(1'b0, 9'h0, 1'b1);
  endtask

  initial begin
    int          rt;
    logic [31:0] sw;
    logic [7:0]  rd;
    bit          rs;
    int          npop;

    vecs[0] = '{8'hA5, 1'b1, 32'h0000_00A5};
    vecs[1] = '{8'h3C, 1'b0, 32'h0000_013C};
    vecs[2] = '{8'h00, 1'b1, 32'h0000_0000};
    vecs[3] = '{8'hFF, 1'b1, 32'h0000_00FF};
    vecs[4] = '{8'h80, 1'b0, 32'h0000_0180};
    model_clear();

    // Reset state, then a quiet idle line.
    repeat (3) tick();
    check("rst_inrdy", {31'b0, InRdy}, 32'h0);
    check("rst_indata", InData, 32'h0);
    check("rst_rxbusy", {31'b0, RxBusy}, 32'h0);
    Reset = 1'b0;
    for (int i = 0; i < 100; i++) begin
      tick();
      check("idle_line", {InData[30:0], InRdy ^ RxBusy}, 32'h0);
      check("idle_flags", {30'b0, InRdy, RxBusy}, 32'h0);
    end

    // Reset in the middle of a frame abandons it.
    RxD = 1'b0;
    repeat (30) tick();
    check("midframe_busy", {31'b0, RxBusy}, 32'h1);
    Reset = 1'b1;
    RxD   = 1'b1;
    repeat (2) tick();
    Reset = 1'b0;
    repeat (100) tick();
    check("midreset_inrdy", {31'b0, InRdy}, 32'h0);
    check("midreset_indata", InData, 32'h0);
    check("midreset_busy", {31'b0, RxBusy}, 32'h0);
    model_clear();

    // Table of single frames received into an empty FIFO.
    for (int i = 0; i < 5; i++) begin
      send_frame(vecs[i].data, vecs[i].stop, -1, rt, sw);
      if (i == 0) check("a5_latency_ok", {31'b0, (rt >= 77 && rt <= 80)}, 32'h1);
      idle(6);
      check("vec_word", InData, vecs[i].exp_word);
      check("vec_inrdy", {31'b0, InRdy}, 32'h1);
      check("vec_busy", {31'b0, RxBusy}, 32'h0);
      pop_check("vec_pop", vecs[i].exp_word);
      check("vec_empty_inrdy", {31'b0, InRdy}, 32'h0);
      check("vec_empty_indata", InData, 32'h0);
    end

    // Framing error with the line held low: parks in WAITHI, single entry.
    send_frame(8'h3C, 1'b0, -1, rt, sw);
    RxD = 1'b0;
    repeat (20) tick();
    check("waithi_busy", {31'b0, RxBusy}, 32'h1);
    pop_check("waithi_word", 32'h0000_013C);
    repeat (20) tick();
    check("waithi_no_second", {31'b0, InRdy}, 32'h0);
    check("waithi_still_busy", {31'b0, RxBusy}, 32'h1);
    idle(6);
    check("waithi_released", {31'b0, RxBusy}, 32'h0);
    check("waithi_after_inrdy", {31'b0, InRdy}, 32'h0);

    // Two-cycle low glitch: START entered, then abandoned at midpoint.
    RxD = 1'b0;
    repeat (2) tick();
    RxD = 1'b1;
    repeat (2) tick();
    check("glitch_start", {31'b0, RxBusy}, 32'h1);
    repeat (12) tick();
    check("glitch_idle", {31'b0, RxBusy}, 32'h0);
    check("glitch_no_push", {31'b0, InRdy}, 32'h0);

    // InStrobe while empty has no effect.
    InStrobe = 1'b1;
    tick();
    InStrobe = 1'b0;
    check("empty_strobe", {InData[30:0], InRdy}, 32'h0);

    // Overrun: fifth byte into a 4-deep FIFO is dropped.
    for (int i = 1; i <= 5; i++) begin
      send_frame(8'(i), 1'b1, -1, rt, sw);
      idle(4);
    end
    pop_check("ovr_pop1", 32'h0000_0201);
    pop_check("ovr_pop2", 32'h0000_0002);
    pop_check("ovr_pop3", 32'h0000_0003);
    pop_check("ovr_pop4", 32'h0000_0004);
    check("ovr_drained", {31'b0, InRdy}, 32'h0);

    // Full FIFO with a pop on the push edge: both happen, no overrun.
    for (int i = 0; i < 4; i++) begin
      send_frame(8'(8'h11 + i), 1'b1, -1, rt, sw);
      idle(4);
    end
    send_frame(8'h15, 1'b1, 78, rt, sw);
    idle(4);
    check("fullpop_read", sw, 32'h0000_0011);
    pop_check("fullpop_1", 32'h0000_0012);
    pop_check("fullpop_2", 32'h0000_0013);
    pop_check("fullpop_3", 32'h0000_0014);
    pop_check("fullpop_4", 32'h0000_0015);
    check("fullpop_empty", {31'b0, InRdy}, 32'h0);

    // Random traffic against the queue model.
    for (int i = 0; i < 24; i++) begin
      rd = 8'($urandom_range(0, 255));
      rs = ($urandom_range(0, 3) != 0);
      send_frame(rd, rs, -1, rt, sw);
      idle(4 + $urandom_range(0, 6));
      check("rnd_word", InData, model_word());
      check("rnd_busy", {31'b0, RxBusy}, 32'h0);
      npop = $urandom_range(0, 2);
      for (int p = 0; p < npop; p++) pop_check("rnd_pop", model_word());
    end
    while (mq.size() > 0) pop_check("rnd_drain", model_word());
    check("rnd_final_inrdy", {31'b0, InRdy}, 32'h0);
    check("rnd_final_indata", InData, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
